// File: rtl/dmem_arbiter_if.sv
// Purpose: groups the core, debug and memory-side signals of the data-memory arbiter.
// Latency: none here; wires only. The arbiter grants in the same cycle and returns read data one cycle later.
// Backpressure: each requester holds its req until gnt is seen; the core additionally sees c_stall.
// Ports: core port c_*, debug port d_*, memory command/return m_*.
// Modports: slave = arbiter side; master = environment (core, debug port, memory).
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  // core load/store stage
  logic          c_req;
  logic          c_we;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_stall;
  logic          c_rvalid;
  logic [DW-1:0] c_rdata;
  // debug/display port
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  // synchronous-read data memory
  logic          m_en;
  logic          m_we;
  logic [AW-3:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  m_rdata,
    output c_gnt, c_stall, c_rvalid, c_rdata,
    output d_gnt, d_rvalid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output m_rdata,
    input  c_gnt, c_stall, c_rvalid, c_rdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Purpose: arbitrates one data-memory port between the core (priority) and the debug port (anti-starvation).
// Latency: grant in the same cycle as the request; read data one cycle after the grant.
// Backpressure: a deferred requester keeps req high; the core is frozen by the combinational c_stall.
// Ports: CLK, Reset (async, active-low), bus (dmem_arbiter_if.slave: c_*, d_*, m_*).
module dmem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4    // 1..15
) (
  input  logic              CLK,
  input  logic              Reset,
  dmem_arbiter_if.slave     bus
);

  typedef enum logic {CORE_PRI, FORCE_DBG} state_t;
  typedef enum logic [1:0] {RS_NONE, RS_CORE, RS_DBG} rsel_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t        r_state;
  logic [3:0]    r_starve_cnt;
  rsel_t         r_rsel;
  logic [DW-1:0] r_d_rdata;

  logic          w_c_gnt;
  logic          w_d_gnt;
  logic [3:0]    w_cnt_inc;
  logic          w_unused_addr_lsbs;

  // Word-addressed memory: the byte offset bits are not used.
  assign w_unused_addr_lsbs = ^{bus.c_addr[1:0], bus.d_addr[1:0]};

  // Priority flips for exactly one cycle once debug has lost STARVE_LIMIT times.
  always_comb begin
    w_c_gnt = 1'b0;
    w_d_gnt = 1'b0;
    if (r_state == FORCE_DBG) begin
      w_d_gnt = bus.d_req;
      w_c_gnt = bus.c_req & ~bus.d_req;
    end else begin
      w_c_gnt = bus.c_req;
      w_d_gnt = bus.d_req & ~bus.c_req;
    end
  end

  assign w_cnt_inc = r_starve_cnt + 4'd1;

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_state      <= CORE_PRI;
      r_starve_cnt <= 4'd0;
      r_rsel       <= RS_NONE;
      r_d_rdata    <= '0;
    end else begin
      case (r_state)
        CORE_PRI: begin
          if (w_d_gnt) begin
            r_starve_cnt <= 4'd0;
          end else if (bus.d_req) begin
            r_starve_cnt <= w_cnt_inc;
            if (w_cnt_inc == LIMIT) r_state <= FORCE_DBG;
          end
        end
        default: begin
          // In FORCE_DBG debug is either granted or no longer requesting,
          // so both exit conditions collapse to an unconditional return.
          r_state      <= CORE_PRI;
          r_starve_cnt <= 4'd0;
        end
      endcase

      // Tag the owner of a granted read so its data is steered next cycle.
      if (w_c_gnt && !bus.c_we)      r_rsel <= RS_CORE;
      else if (w_d_gnt && !bus.d_we) r_rsel <= RS_DBG;
      else                           r_rsel <= RS_NONE;

      if (r_rsel == RS_DBG) r_d_rdata <= bus.m_rdata;
    end
  end

  assign bus.c_gnt    = w_c_gnt;
  assign bus.d_gnt    = w_d_gnt;
  assign bus.c_stall  = bus.c_req & ~w_c_gnt;
  assign bus.c_rvalid = (r_rsel == RS_CORE);
  assign bus.d_rvalid = (r_rsel == RS_DBG);
  assign bus.c_rdata  = bus.m_rdata;
  assign bus.d_rdata  = r_d_rdata;

  // Memory command is zero when idle.
  assign bus.m_en    = w_c_gnt | w_d_gnt;
  assign bus.m_we    = (w_c_gnt & bus.c_we) | (w_d_gnt & bus.d_we);
  assign bus.m_addr  = w_c_gnt ? bus.c_addr[AW-1:2]  : (w_d_gnt ? bus.d_addr[AW-1:2]  : '0);
  assign bus.m_wdata = w_c_gnt ? bus.c_wdata         : (w_d_gnt ? bus.d_wdata         : '0);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Purpose: checks dmem_arbiter against a priority/starvation reference model with directed and random traffic.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: requesters hold their request until granted.
module tb_dmem_arbiter;
  localparam int LIMIT = 4;

  logic CLK;
  logic Reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) bus();

  dmem_arbiter #(.AW(32), .DW(32), .STARVE_LIMIT(LIMIT)) dut (
    .CLK  (CLK),
    .Reset(Reset),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Synchronous-read data memory, 16 words.
  logic [31:0] mem [16];
  always @(posedge CLK) begin
    if (bus.m_en) begin
      if (bus.m_we) mem[bus.m_addr[3:0]] <= bus.m_wdata;
      else          bus.m_rdata <= mem[bus.m_addr[3:0]];
    end
  end

  // Reference model: debug lost-cycle count, pending read, memory image.
  int          lost;
  bit          pend_c, pend_d;
  logic [31:0] pend_val;
  logic [31:0] exp_drd;
  logic [31:0] mm [16];
  bit          last_gc, last_gd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    lost = 0; pend_c = 0; pend_d = 0; exp_drd = 0; last_gc = 0; last_gd = 0;
  endtask

  // Called on the falling edge: compare, then advance the model past the next rising edge.
  task automatic step_check();
    bit prio, gc, gd, ewe;
    logic [31:0] ea, ed;
    prio = (lost >= LIMIT);
    gc   = bus.c_req && !(prio && bus.d_req);
    gd   = bus.d_req && !gc;
    ewe  = gc ? bus.c_we : (gd ? bus.d_we : 1'b0);
    ea   = gc ? (bus.c_addr >> 2) : (gd ? (bus.d_addr >> 2) : 32'd0);
    ed   = gc ? bus.c_wdata : (gd ? bus.d_wdata : 32'd0);
    chk("c_gnt",    32'(bus.c_gnt),    32'(gc));
    chk("d_gnt",    32'(bus.d_gnt),    32'(gd));
    chk("c_stall",  32'(bus.c_stall),  32'(bus.c_req && !gc));
    chk("m_en",     32'(bus.m_en),     32'(gc || gd));
    chk("m_we",     32'(bus.m_we),     32'(ewe));
    chk("m_addr",   32'(bus.m_addr),   ea);
    chk("m_wdata",  bus.m_wdata,       ed);
    chk("c_rvalid", 32'(bus.c_rvalid), 32'(pend_c));
    chk("d_rvalid", 32'(bus.d_rvalid), 32'(pend_d));
    if (pend_c) chk("c_rdata", bus.c_rdata, pend_val);
    chk("d_rdata",  bus.d_rdata,       exp_drd);
    if (pend_d) exp_drd = pend_val;
    pend_c   = gc && !bus.c_we;
    pend_d   = gd && !bus.d_we;
    pend_val = gc ? mm[bus.c_addr[5:2]] : mm[bus.d_addr[5:2]];
    if (gc && bus.c_we) mm[bus.c_addr[5:2]] = bus.c_wdata;
    if (gd && bus.d_we) mm[bus.d_addr[5:2]] = bus.d_wdata;
    if (gd || prio)      lost = 0;
    else if (bus.d_req)  lost = lost + 1;
    last_gc = gc;
    last_gd = gd;
  endtask

  task automatic cycle(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd);
    @(posedge CLK); #1;
    bus.c_req = cr; bus.c_we = cw; bus.c_addr = ca; bus.c_wdata = cd;
    bus.d_req = dr; bus.d_we = dw; bus.d_addr = da; bus.d_wdata = dd;
    @(negedge CLK);
    step_check();
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_c_gnt"},    32'(bus.c_gnt),    0);
    chk({tag, "_d_gnt"},    32'(bus.d_gnt),    0);
    chk({tag, "_c_stall"},  32'(bus.c_stall),  0);
    chk({tag, "_c_rvalid"}, 32'(bus.c_rvalid), 0);
    chk({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 0);
    chk({tag, "_m_en"},     32'(bus.m_en),     0);
    chk({tag, "_m_we"},     32'(bus.m_we),     0);
    chk({tag, "_m_addr"},   32'(bus.m_addr),   0);
    chk({tag, "_m_wdata"},  bus.m_wdata,       0);
    chk({tag, "_d_rdata"},  bus.d_rdata,       0);
  endtask

  bit          cr, cw, dr, dw;
  logic [31:0] ca, cd, da, dd;

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = 0; mm[i] = 0; end
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    model_reset();
    Reset = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge CLK); Reset = 1'b1;

    // Reset mid-read: the core read return must be discarded.
    cycle(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(posedge CLK); #1;
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = 0; bus.c_wdata = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    Reset = 1'b0;
    #2;
    chk_reset_outputs("midrst");
    @(negedge CLK); Reset = 1'b1;
    model_reset();
    idle();
    chk("rst_no_rvalid", 32'(bus.c_rvalid), 0);
    cycle(1, 0, 32'h4, 0, 1, 0, 32'h4, 0);
    chk("rst_core_pri", 32'(bus.c_gnt), 1);
    idle();

    // Core only: write then read back.
    cycle(1, 1, 32'h24, 32'hDEADBEEF, 0, 0, 0, 0);
    chk("core_wr_gnt", 32'(bus.c_gnt), 1);
    chk("core_wr_stall", 32'(bus.c_stall), 0);
    cycle(1, 0, 32'h24, 0, 0, 0, 0, 0);
    chk("core_rd_gnt", 32'(bus.c_gnt), 1);
    idle();
    chk("core_rvalid", 32'(bus.c_rvalid), 1);
    chk("core_rdata", bus.c_rdata, 32'hDEADBEEF);

    // Debug only: read, then data held after the request drops.
    cycle(0, 0, 0, 0, 1, 0, 32'h24, 0);
    chk("dbg_gnt", 32'(bus.d_gnt), 1);
    idle();
    chk("dbg_rvalid", 32'(bus.d_rvalid), 1);
    idle();
    chk("dbg_rdata", bus.d_rdata, 32'hDEADBEEF);
    idle();
    chk("dbg_rdata_hold", bus.d_rdata, 32'hDEADBEEF);

    // Simultaneous start in CORE_PRI.
    cycle(1, 1, 32'h8, 32'h1, 1, 0, 32'h8, 0);
    chk("sim_core_first", 32'(bus.c_gnt), 1);
    chk("sim_dbg_wait", 32'(bus.d_gnt), 0);
    cycle(0, 0, 0, 0, 1, 0, 32'h8, 0);
    chk("sim_dbg_next", 32'(bus.d_gnt), 1);
    idle();
    idle();
    chk("sim_dbg_data", bus.d_rdata, 32'h1);

    // Continuous contention: debug wins every fifth cycle.
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 32'(i * 4), 0, 1, 0, 32'h24, 0);
      chk("cont_dgnt", 32'(bus.d_gnt), 32'((i % 5) == 4));
      chk("cont_stall", 32'(bus.c_stall), 32'((i % 5) == 4));
    end

    // Debug drops its request while forced: core goes through, counter restarts.
    for (int i = 0; i < LIMIT; i++) cycle(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    cycle(1, 0, 32'h4, 0, 0, 0, 0, 0);
    chk("drop_cgnt", 32'(bus.c_gnt), 1);
    chk("drop_stall", 32'(bus.c_stall), 0);
    for (int i = 0; i < LIMIT; i++) begin
      cycle(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
      chk("drop_core_pri", 32'(bus.c_gnt), 1);
    end
    cycle(1, 0, 32'h4, 0, 1, 0, 32'h8, 0);
    chk("drop_dbg_again", 32'(bus.d_gnt), 1);
    idle();

    // Random traffic, each requester holding until granted.
    cr = 0; dr = 0; cw = 0; dw = 0; ca = 0; da = 0; cd = 0; dd = 0;
    last_gc = 0; last_gd = 0;
    for (int n = 0; n < 400; n++) begin
      if (!cr || last_gc) begin
        cr = ($urandom % 4) != 0;
        cw = $urandom % 2;
        ca = {26'd0, 4'($urandom % 16), 2'($urandom % 4)};
        cd = $urandom;
      end
      if (!dr || last_gd) begin
        dr = ($urandom % 3) != 0;
        dw = ($urandom % 4) == 0;
        da = {26'd0, 4'($urandom % 16), 2'($urandom % 4)};
        dd = $urandom;
      end
      cycle(cr, cw, ca, cd, dr, dw, da, dd);
    end
    idle();
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single data-memory port between the pipelined MIPS core's load/store stage and the debug/display port. The core has priority; a starvation counter guarantees the debug port a slot after `STARVE_LIMIT` consecutive lost cycles. The block drives a synchronous-read data memory, routes one-cycle-latency read data back to the winner, and asserts a stall to the core whenever its access is deferred. It sits between `mips` and `dmem` inside `mips_top`.

## Interface

- `AW`, 32: byte-address width of both requester ports.
- `DW`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive deferred debug cycles before debug is forced through. Legal range is 1..15.

- `CLK`  in  1: clock. All state updates on the rising edge.
- `Reset`  in  1: asynchronous, active-low reset.
- `c_req`  in  1: core access request. Held stable until granted.
- `c_we`  in  1: core write (1) or read (0).
- `c_addr`  in  AW: core byte address. Bits [1:0] are ignored.
- `c_wdata`  in  DW: core write data.
- `c_gnt`  out  1: core access accepted this cycle.
- `c_stall`  out  1: `c_req & ~c_gnt`. Freezes the core pipeline.
- `c_rvalid`  out  1: core read data valid.
- `c_rdata`  out  DW: core read data. Equals `m_rdata`; meaningful only while `c_rvalid` is high.
- `d_req`, `d_we`, `d_addr` (AW), `d_wdata` (DW)  in: debug request. Same semantics as the core port.
- `d_gnt`  out  1: debug access accepted this cycle.
- `d_rvalid`  out  1: debug read data valid.
- `d_rdata`  out  DW: registered hold of the last debug read. Stable until the next debug read completes.
- `m_en`  out  1: memory access this cycle.
- `m_we`  out  1: memory write strobe.
- `m_addr`  out  AW-2: word address.
- `m_wdata`  out  DW: memory write data.
- `m_rdata`  in  DW: memory read data. Valid one cycle after a read is enabled.

## Operation

- At most one grant per cycle. Grants are combinational from `c_req`, `d_req` and the registered arbitration state.
- Arbitration state machine, two states:
  - **CORE_PRI** (reset state): grant core if `c_req`, else grant debug if `d_req`.
  - **FORCE_DBG**: grant debug if `d_req`, else grant core if `c_req`.
- Starvation counter `starve_cnt`, width 4, reset to 0:
  - Increments when `d_req & ~d_gnt`.
  - Clears on `d_gnt`.
  - Holds when `d_req` is low.
- State transitions:
  - CORE_PRI -> FORCE_DBG on the edge where `starve_cnt` becomes `STARVE_LIMIT`.
  - FORCE_DBG -> CORE_PRI on the edge following `d_gnt`, or when `d_req` deasserts (the counter also clears in that case).
- Memory command mux:
  - `m_en` = `c_gnt | d_gnt`.
  - `m_we`, `m_addr` and `m_wdata` are taken from the granted port.
  - `m_addr` = `addr[AW-1:2]`.
  - With no grant, all memory command outputs are 0.
- Read return: a registered tag `rsel` (NONE/CORE/DBG) records a granted read.
  - Next cycle, `c_rvalid` = (`rsel == CORE`) and `d_rvalid` = (`rsel == DBG`).
  - On a DBG return, `d_rdata` captures `m_rdata` at the following edge.
  - Writes produce no rvalid.
- Simultaneous requests:
  - In CORE_PRI the core wins and debug is deferred.
  - In FORCE_DBG debug wins and the core stalls for exactly that cycle.
- Reset, asserted at any time: state = CORE_PRI, `starve_cnt` = 0, `rsel` = NONE, `d_rdata` = 0. Any in-flight read return is discarded (no rvalid after reset release).
- Reset values of outputs: `c_gnt` = `d_gnt` = `c_stall` = `c_rvalid` = `d_rvalid` = 0; `m_en` = `m_we` = 0; `m_addr` = `m_wdata` = 0; `d_rdata` = 0.

## Timing

- Grant latency is 0 cycles: the request is granted in the same cycle it is presented.
- Read data latency is 1 cycle after grant. Back-to-back reads on consecutive cycles are supported, including alternating owners.
- A write commits at the rising edge that ends its grant cycle. A read in the next cycle sees the new data.
- Worst-case debug wait is `STARVE_LIMIT`+1 cycles under continuous `c_req`.
- Under continuous `d_req` and `c_req`, the core loses at most 1 of every `STARVE_LIMIT`+1 cycles.
- `c_stall` is combinational and must meet same-cycle timing into the core's pipeline enables.

## Test plan

- Reset mid-read: core read of 0x10 granted, `Reset` pulsed low on the next cycle -> no `c_rvalid`; all outputs at reset values; state back in CORE_PRI.
- Core only: write 0xDEADBEEF to 0x24, then read 0x24 -> `c_gnt`=1 both cycles, `c_stall`=0, `c_rvalid`=1 with `c_rdata`=0xDEADBEEF one cycle after the read grant.
- Debug only: read 0x24 -> `d_gnt` same cycle; `d_rvalid`=1 next cycle; `d_rdata`=0xDEADBEEF and held after `d_req` drops.
- Contention, `STARVE_LIMIT`=4: `c_req` and `d_req` held high continuously -> debug is granted on cycle 5, with `c_stall`=1 only on that cycle; the pattern repeats every 5 cycles.
- Simultaneous start, CORE_PRI: core write 0x1 to 0x8 and debug read 0x8 -> core granted first; debug granted the next cycle (core idle) and returns 0x1.
- FORCE_DBG with `d_req` dropped before its grant -> the core is granted that cycle with no stall; state returns to CORE_PRI; `starve_cnt`=0.
